// File: rtl/wb_result_arbiter_pkg.sv
// Shared types for the writeback result arbiter.
//   wb_src_e    : result source index order (FLU, LOAD, STORE, FPU, X)
//   exception_t : exception record carried with each result
//   wb_entry_t  : one buffered result (trans_id, result, ex)
package wb_result_arbiter_pkg;
   localparam int unsigned XLEN          = 64;
   localparam int unsigned TRANS_ID_BITS = 6;
   localparam int unsigned WB_ARB_NR_SRC = 5;

   typedef enum logic [2:0] {
      SRC_FLU   = 3'd0,
      SRC_LOAD  = 3'd1,
      SRC_STORE = 3'd2,
      SRC_FPU   = 3'd3,
      SRC_X     = 3'd4
   } wb_src_e;

   typedef struct packed {
      logic [XLEN-1:0] cause;
      logic [XLEN-1:0] tval;
      logic            valid;
   } exception_t;

   typedef struct packed {
      logic [TRANS_ID_BITS-1:0] trans_id;
      logic [XLEN-1:0]          result;
      exception_t               ex;
   } wb_entry_t;
endpackage

// File: rtl/wb_result_arbiter_fifo.sv
// wb_src_fifo: single-source FIFO of wb_entry_t with synchronous clear.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : synchronous clear (flush)
//   push_i/data_i: enqueue; ignored when full unless popping the same cycle
//   pop_i        : dequeue head (ignored when empty)
//   full_o, empty_o, count_o, head_o : status and head entry
module wb_src_fifo
   import wb_result_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clr_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  wb_entry_t                data_i,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output wb_entry_t                head_o
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   wb_entry_t       mem_q [DEPTH];
   logic [AW-1:0]   rd_q, wr_q;
   logic [CW-1:0]   cnt_q;
   logic            do_push, do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign head_o  = mem_q[rd_q];

   // A full FIFO still accepts a push when its head leaves in the same cycle.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset: an entry is only observed after being written.
   always_ff @(posedge clk_i) begin
      if (do_push && !rst_i && !clr_i) mem_q[wr_q] <= data_i;
   end
endmodule

// File: rtl/wb_result_arbiter.sv
// wb_result_arbiter: buffers each execute-stage result source in a small
// FIFO and grants up to NR_WB_PORTS results per cycle, round-robin.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   flush_i                 : drop buffered and incoming results
//   src_valid_i/_trans_id_i/_result_i/_ex_i : per-source results
//   src_ready_o             : source may issue (count <= FIFO_DEPTH-2)
//   wb_valid_o/_trans_id_o/_data_o/_ex_o    : writeback ports
//   overflow_o              : sticky, a result arrived while its FIFO was full
// Optional: define WB_ARB_BYPASS_EN to let a source with an empty FIFO be
// granted straight from its inputs (0-cycle latency). Without it every result
// is buffered first and wb_* come only from FIFO heads.
module wb_result_arbiter
   import wb_result_arbiter_pkg::*;
#(
   parameter int unsigned NR_SRC      = WB_ARB_NR_SRC,
   parameter int unsigned NR_WB_PORTS = 4,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                                        clk_i,
   input  logic                                        rst_i,
   input  logic                                        flush_i,
   input  logic [NR_SRC-1:0]                           src_valid_i,
   input  logic [NR_SRC-1:0][TRANS_ID_BITS-1:0]        src_trans_id_i,
   input  logic [NR_SRC-1:0][XLEN-1:0]                 src_result_i,
   input  exception_t [NR_SRC-1:0]                     src_ex_i,
   output logic [NR_SRC-1:0]                           src_ready_o,
   output logic [NR_WB_PORTS-1:0]                      wb_valid_o,
   output logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]   wb_trans_id_o,
   output logic [NR_WB_PORTS-1:0][XLEN-1:0]            wb_data_o,
   output exception_t [NR_WB_PORTS-1:0]                wb_ex_o,
   output logic                                        overflow_o
);
   localparam int unsigned RRW = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;
   localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;

   logic [NR_SRC-1:0]           full, empty, cand, gnt, push, pop;
   logic [NR_SRC-1:0][CW-1:0]   count;
   wb_entry_t [NR_SRC-1:0]      head, in_e, sel;
   logic [RRW-1:0]              rr_q, rr_d;
   logic                        ovf_q;
   logic                        kill;
   int unsigned                 pos  [NR_SRC];
   int unsigned                 rank [NR_SRC];
   int unsigned                 best;

   assign kill = rst_i | flush_i;

   for (genvar s = 0; s < NR_SRC; s++) begin : g_src
      assign in_e[s] = '{trans_id: src_trans_id_i[s], result: src_result_i[s], ex: src_ex_i[s]};

      wb_src_fifo #(.DEPTH(FIFO_DEPTH)) i_fifo (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .clr_i   (flush_i),
         .push_i  (push[s]),
         .pop_i   (pop[s]),
         .data_i  (in_e[s]),
         .full_o  (full[s]),
         .empty_o (empty[s]),
         .count_o (count[s]),
         .head_o  (head[s])
      );

      assign src_ready_o[s] = (count[s] <= CW'(FIFO_DEPTH - 2));

`ifdef WB_ARB_BYPASS_EN
      assign cand[s] = ~empty[s] | src_valid_i[s];
      assign sel[s]  = empty[s] ? in_e[s] : head[s];
      // A bypass-granted result never enters the FIFO.
      assign push[s] = src_valid_i[s] & ~(gnt[s] & empty[s]) & ~kill;
`else
      assign cand[s] = ~empty[s];
      assign sel[s]  = head[s];
      assign push[s] = src_valid_i[s] & ~kill;
`endif
      assign pop[s]  = gnt[s] & ~empty[s];
   end

   // pos = scan distance from rr_q; rank = candidates seen earlier in the scan.
   // Granting on rank < NR_WB_PORTS keeps every array index a loop constant.
   always_comb begin
      gnt           = '0;
      wb_valid_o    = '0;
      wb_trans_id_o = '0;
      wb_data_o     = '0;
      wb_ex_o       = '0;
      rr_d          = rr_q;
      best          = 0;
      for (int s = 0; s < NR_SRC; s++) begin
         pos[s]  = (s + NR_SRC - int'(rr_q)) % NR_SRC;
         rank[s] = 0;
      end
      for (int s = 0; s < NR_SRC; s++)
         for (int t = 0; t < NR_SRC; t++)
            if (cand[t] && pos[t] < pos[s]) rank[s] = rank[s] + 1;
      for (int s = 0; s < NR_SRC; s++)
         gnt[s] = cand[s] && (rank[s] < NR_WB_PORTS) && !kill;
      for (int p = 0; p < NR_WB_PORTS; p++)
         for (int s = 0; s < NR_SRC; s++)
            if (gnt[s] && rank[s] == p) begin
               wb_valid_o[p]    = 1'b1;
               wb_trans_id_o[p] = sel[s].trans_id;
               wb_data_o[p]     = sel[s].result;
               wb_ex_o[p]       = sel[s].ex;
            end
      // Next scan starts after the granted source farthest along the scan.
      for (int s = 0; s < NR_SRC; s++)
         if (gnt[s] && pos[s] >= best) begin
            best = pos[s];
            rr_d = RRW'((s + 1) % NR_SRC);
         end
      if (flush_i) rr_d = '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_q  <= '0;
         ovf_q <= 1'b0;
      end else begin
         rr_q <= rr_d;
         if (|(push & full & ~pop)) ovf_q <= 1'b1;
      end
   end

   assign overflow_o = ovf_q;
endmodule

// File: tb/tb_wb_result_arbiter.sv
module tb_wb_result_arbiter;
   import wb_result_arbiter_pkg::*;

   localparam int NS = 5;
   localparam int NP = 4;
   localparam int D  = 4;
`ifdef WB_ARB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                                  clk = 1'b0;
   logic                                  rst, flush;
   logic [NS-1:0]                         src_valid_i;
   logic [NS-1:0][TRANS_ID_BITS-1:0]      src_trans_id_i;
   logic [NS-1:0][XLEN-1:0]               src_result_i;
   exception_t [NS-1:0]                   src_ex_i;
   logic [NS-1:0]                         src_ready_o;
   logic [NP-1:0]                         wb_valid_o;
   logic [NP-1:0][TRANS_ID_BITS-1:0]      wb_trans_id_o;
   logic [NP-1:0][XLEN-1:0]               wb_data_o;
   exception_t [NP-1:0]                   wb_ex_o;
   logic                                  overflow_o;

   wb_result_arbiter #(.NR_SRC(NS), .NR_WB_PORTS(NP), .FIFO_DEPTH(D)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .src_valid_i(src_valid_i), .src_trans_id_i(src_trans_id_i),
      .src_result_i(src_result_i), .src_ex_i(src_ex_i),
      .src_ready_o(src_ready_o), .wb_valid_o(wb_valid_o),
      .wb_trans_id_o(wb_trans_id_o), .wb_data_o(wb_data_o),
      .wb_ex_o(wb_ex_o), .overflow_o(overflow_o)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: per-source queues, scan pointer, sticky overflow.
   wb_entry_t q [NS][$];
   int        rr;
   bit        ovf;

   logic [NS-1:0] in_v;
   wb_entry_t     in_e [NS];

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic wb_entry_t mk(input int id);
      wb_entry_t e;
      e.trans_id = TRANS_ID_BITS'(id);
      e.result   = XLEN'(id * 1000 + 7);
      e.ex       = '0;
      return e;
   endfunction

   function automatic wb_entry_t rnd_e();
      wb_entry_t e;
      e.trans_id = TRANS_ID_BITS'($urandom);
      e.result   = {$urandom, $urandom};
      e.ex.cause = {$urandom, $urandom};
      e.ex.tval  = {$urandom, $urandom};
      e.ex.valid = 1'($urandom);
      return e;
   endfunction

   function automatic wb_entry_t port_e(input int p);
      return '{trans_id: wb_trans_id_o[p], result: wb_data_o[p], ex: wb_ex_o[p]};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; flush = 1'b0; src_valid_i = '0;
      src_trans_id_i = '0; src_result_i = '0; src_ex_i = '0;
      @(negedge clk);
      for (int s = 0; s < NS; s++) q[s].delete();
      rr = 0; ovf = 1'b0;
   endtask

   // Drive one cycle, compare all outputs against the model, advance the model.
   task automatic step(input logic fl);
      logic [NP-1:0] exp_v;
      wb_entry_t     exp_e [NP];
      logic [NS-1:0] g, byp;
      int            n, last;
      @(negedge clk);
      rst = 1'b0; flush = fl; src_valid_i = in_v;
      for (int s = 0; s < NS; s++) begin
         src_trans_id_i[s] = in_e[s].trans_id;
         src_result_i[s]   = in_e[s].result;
         src_ex_i[s]       = in_e[s].ex;
      end
      #1;
      exp_v = '0; g = '0; byp = '0; n = 0; last = -1;
      for (int p = 0; p < NP; p++) exp_e[p] = '0;
      if (!fl) begin
         for (int i = 0; i < NS; i++) begin
            int  s;
            bit  has;
            s   = (rr + i) % NS;
            has = q[s].size() > 0;
            if ((has || (BYP && in_v[s])) && n < NP) begin
               exp_e[n] = has ? q[s][0] : in_e[s];
               exp_v[n] = 1'b1;
               g[s] = 1'b1;
               byp[s] = !has;
               n++;
               last = s;
            end
         end
      end
      chk("wb_valid", 256'(wb_valid_o), 256'(exp_v));
      for (int p = 0; p < NP; p++)
         chk($sformatf("wb_port%0d", p), 256'(port_e(p)), 256'(exp_e[p]));
      for (int s = 0; s < NS; s++)
         chk($sformatf("ready%0d", s), 256'(src_ready_o[s]), 256'(q[s].size() <= D - 2));
      chk("overflow", 256'(overflow_o), 256'(ovf));
      if (fl) begin
         for (int s = 0; s < NS; s++) q[s].delete();
         rr = 0;
      end else begin
         for (int s = 0; s < NS; s++) begin
            if (g[s] && !byp[s]) void'(q[s].pop_front());
            if (in_v[s] && !byp[s]) begin
               if (q[s].size() < D) q[s].push_back(in_e[s]);
               else ovf = 1'b1;
            end
         end
         if (last >= 0) rr = (last + 1) % NS;
      end
   endtask

   task automatic idle();
      in_v = '0;
      for (int s = 0; s < NS; s++) in_e[s] = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; flush = 1'b0;
      idle();
      do_reset();

      // Reset release, nothing valid.
      step(1'b0);
      chk("rst_wb_valid", 256'(wb_valid_o), 256'(4'b0000));
      chk("rst_ready",    256'(src_ready_o), 256'(5'b11111));
      chk("rst_ovf",      256'(overflow_o), 256'(1'b0));

      // All five sources valid with IDs 1..5 in one cycle.
      for (int s = 0; s < NS; s++) begin in_v[s] = 1'b1; in_e[s] = mk(s + 1); end
      step(1'b0);
      idle();
`ifdef WB_ARB_BYPASS_EN
      chk("all5_c0_valid", 256'(wb_valid_o), 256'(4'b1111));
      chk("all5_c0_p0", 256'(wb_trans_id_o[0]), 256'(1));
      chk("all5_c0_p3", 256'(wb_trans_id_o[3]), 256'(4));
      step(1'b0);
      chk("all5_c1_valid", 256'(wb_valid_o), 256'(4'b0001));
      chk("all5_c1_p0", 256'(wb_trans_id_o[0]), 256'(5));
`else
      chk("all5_c0_valid", 256'(wb_valid_o), 256'(4'b0000));
      step(1'b0);
      chk("all5_c1_valid", 256'(wb_valid_o), 256'(4'b1111));
      chk("all5_c1_p0", 256'(wb_trans_id_o[0]), 256'(1));
      chk("all5_c1_p3", 256'(wb_trans_id_o[3]), 256'(4));
      step(1'b0);
      chk("all5_c2_valid", 256'(wb_valid_o), 256'(4'b0001));
      chk("all5_c2_p0", 256'(wb_trans_id_o[0]), 256'(5));
`endif
      step(1'b0);

      // Single FLU result ID 7.
      do_reset();
      in_v[SRC_FLU] = 1'b1; in_e[SRC_FLU] = mk(7);
      step(1'b0);
      idle();
`ifndef WB_ARB_BYPASS_EN
      chk("flu7_c0_valid", 256'(wb_valid_o), 256'(4'b0000));
      step(1'b0);
`endif
      chk("flu7_valid", 256'(wb_valid_o), 256'(4'b0001));
      chk("flu7_id",    256'(wb_trans_id_o[0]), 256'(7));
      step(1'b0);

      // Sustained 5-in / 4-out traffic must eventually overflow some FIFO.
      do_reset();
      for (int c = 0; c < 40; c++) begin
         for (int s = 0; s < NS; s++) begin in_v[s] = 1'b1; in_e[s] = rnd_e(); end
         step(1'b0);
      end
      idle();
      step(1'b0);
      chk("sustain_ovf", 256'(overflow_o), 256'(1'b1));

      // Build up backlog, then flush with an incoming FPU result.
      do_reset();
      for (int c = 0; c < 6; c++) begin
         for (int s = 0; s < NS; s++) begin in_v[s] = 1'b1; in_e[s] = mk(10 + c * NS + s); end
         step(1'b0);
      end
      idle();
      in_v[SRC_FPU] = 1'b1; in_e[SRC_FPU] = mk(12);
      step(1'b1);
      chk("flush_valid", 256'(wb_valid_o), 256'(4'b0000));
      idle();
      step(1'b0);
      chk("post_flush_valid", 256'(wb_valid_o), 256'(4'b0000));
      chk("post_flush_ready", 256'(src_ready_o), 256'(5'b11111));

      // Random traffic with occasional flushes.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         int dens;
         dens = (c / 500) % 3;   // vary load: light, medium, heavy
         for (int s = 0; s < NS; s++) begin
            in_v[s] = ($urandom_range(0, 9) < (dens * 3 + 2));
            in_e[s] = rnd_e();
         end
         step($urandom_range(0, 63) == 0);
      end
      idle();
      for (int c = 0; c < 8; c++) step(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
